// File: rtl/e203_icb_sram_slv_pkg.sv
// Shared definitions for the ICB-to-SRAM responder: size encodings, defaults, response entry.
package e203_icb_sram_slv_pkg;

  localparam int unsigned E203_XLEN = 32;

  localparam logic [1:0] ICB_SIZE_BYTE = 2'd0;
  localparam logic [1:0] ICB_SIZE_HALF = 2'd1;
  localparam logic [1:0] ICB_SIZE_WORD = 2'd2;
  localparam logic [1:0] ICB_SIZE_RSVD = 2'd3;

  localparam int unsigned SRAM_AW_DFLT   = 16;
  localparam logic [31:0] SRAM_BASE_DFLT = 32'h9000_0000;

  // One buffered response: error flag, exclusive-success flag and read data.
  typedef struct packed {
    logic                 err;
    logic                 excl_ok;
    logic [E203_XLEN-1:0] rdata;
  } rsp_ent_t;

  localparam int unsigned RSP_W = $bits(rsp_ent_t);

endpackage

// File: rtl/e203_icb_rsp_buf.sv
// Two-entry synchronous response FIFO; full/empty are registered flags.
module e203_icb_rsp_buf
  import e203_icb_sram_slv_pkg::*;
#(
  parameter int unsigned W = RSP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic [1:0]   cnt_nxt;

  // Entry count after this cycle's push/pop.
  always_comb begin
    cnt_nxt = cnt + 2'(push) - 2'(pop);
  end

  // Storage, pointers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == 2'd2);
      empty <= (cnt_nxt == 2'd0);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/e203_icb_sram_slv.sv
// ICB responder in front of a 1-cycle-latency single-port SRAM with an LR/SC monitor.
module e203_icb_sram_slv
  import e203_icb_sram_slv_pkg::*;
#(
  parameter int unsigned AW   = SRAM_AW_DFLT,
  parameter logic [31:0] BASE = SRAM_BASE_DFLT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          icb_cmd_valid,
  output logic          icb_cmd_ready,
  input  logic [31:0]   icb_cmd_addr,
  input  logic          icb_cmd_read,
  input  logic [31:0]   icb_cmd_wdata,
  input  logic [3:0]    icb_cmd_wmask,
  input  logic          icb_cmd_lock,
  input  logic          icb_cmd_excl,
  input  logic [1:0]    icb_cmd_size,
  output logic          icb_rsp_valid,
  input  logic          icb_rsp_ready,
  output logic          icb_rsp_err,
  output logic          icb_rsp_excl_ok,
  output logic [31:0]   icb_rsp_rdata,
  input  logic          excl_clr,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-3:0] ram_addr,
  output logic [3:0]    ram_wem,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout
);

  localparam int unsigned WAW = AW - 2;

  logic           accept;
  logic           rng_err;
  logic           aln_err;
  logic           cmd_err;
  logic [WAW-1:0] cmd_word;
  logic           resv_hit;
  logic           excl_wr;
  logic           excl_ok;
  logic           rsp_hs;
  logic [1:0]     occ;
  logic [1:0]     occ_nxt;

  logic           if_vld;
  logic           if_err;
  logic           if_eok;
  logic           if_read;

  logic           resv_vld;
  logic [WAW-1:0] resv_addr;

  logic             buf_push;
  logic             buf_pop;
  logic [RSP_W-1:0] buf_dout;
  logic             buf_full;
  logic             buf_empty;
  rsp_ent_t         if_ent;
  rsp_ent_t         head_ent;
  rsp_ent_t         out_ent;
  logic             unused_lock_full;

  // Command decode: range/alignment error, reservation match, SRAM access.
  assign accept   = icb_cmd_valid & icb_cmd_ready;
  assign rng_err  = (icb_cmd_addr[31:AW] != BASE[31:AW]);
  assign aln_err  = ((icb_cmd_size == ICB_SIZE_HALF) & icb_cmd_addr[0])
                  | ((icb_cmd_size == ICB_SIZE_WORD) & (icb_cmd_addr[1:0] != 2'b00))
                  | (icb_cmd_size == ICB_SIZE_RSVD);
  assign cmd_err  = rng_err | aln_err;
  assign cmd_word = icb_cmd_addr[AW-1:2];
  assign resv_hit = resv_vld & (resv_addr == cmd_word);
  assign excl_wr  = accept & ~cmd_err & icb_cmd_excl & ~icb_cmd_read;
  assign excl_ok  = excl_wr & resv_hit;

  assign ram_cs   = accept & ~cmd_err & ~(excl_wr & ~resv_hit);
  assign ram_we   = ~icb_cmd_read;
  assign ram_wem  = icb_cmd_wmask & {4{~icb_cmd_read}};
  assign ram_addr = cmd_word;
  assign ram_din  = icb_cmd_wdata;

  // Occupancy: accepted-but-unanswered commands; cmd_ready is registered from it.
  assign rsp_hs  = icb_rsp_valid & icb_rsp_ready;
  assign occ_nxt = occ + 2'(accept) - 2'(rsp_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ           <= 2'd0;
      icb_cmd_ready <= 1'b1;
    end else begin
      occ           <= occ_nxt;
      icb_cmd_ready <= (occ_nxt < 2'd2);
    end
  end

  // One-cycle in-flight stage, waiting for the SRAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_vld  <= 1'b0;
      if_err  <= 1'b0;
      if_eok  <= 1'b0;
      if_read <= 1'b0;
    end else begin
      if_vld  <= accept;
      if_err  <= cmd_err;
      if_eok  <= excl_ok;
      if_read <= icb_cmd_read;
    end
  end

  // Exclusive monitor; excl_clr wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_vld  <= 1'b0;
      resv_addr <= '0;
    end else if (excl_clr) begin
      resv_vld <= 1'b0;
    end else if (accept & ~cmd_err) begin
      if (icb_cmd_read & icb_cmd_excl) begin
        resv_vld  <= 1'b1;
        resv_addr <= cmd_word;
      end else if (~icb_cmd_read & (icb_cmd_excl | resv_hit)) begin
        resv_vld <= 1'b0;
      end
    end
  end

  // Response selection: buffer head if anything is queued, else the in-flight entry.
  always_comb begin
    if_ent         = '0;
    if_ent.err     = if_vld & if_err;
    if_ent.excl_ok = if_vld & if_eok;
    if_ent.rdata   = (if_vld & if_read & ~if_err) ? ram_dout : '0;
    head_ent       = rsp_ent_t'(buf_dout);
    out_ent        = buf_empty ? if_ent : head_ent;
  end

  // In-flight entry goes into the buffer unless it is presented and taken right away.
  assign buf_push = if_vld & ~(buf_empty & icb_rsp_ready);
  assign buf_pop  = ~buf_empty & icb_rsp_ready;

  e203_icb_rsp_buf #(.W(RSP_W)) u_rsp_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (buf_push),
    .din   (RSP_W'(if_ent)),
    .pop   (buf_pop),
    .dout  (buf_dout),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign icb_rsp_valid   = ~buf_empty | if_vld;
  assign icb_rsp_err     = out_ent.err;
  assign icb_rsp_excl_ok = out_ent.excl_ok;
  assign icb_rsp_rdata   = out_ent.rdata;

  // Lock is not used by this memory; occupancy already prevents buffer overflow.
  assign unused_lock_full = icb_cmd_lock | buf_full;

endmodule

// File: tb/tb_e203_icb_sram_slv.sv
// Self-checking bench for e203_icb_sram_slv: vector table, corner sequences, random vs model.
module tb_e203_icb_sram_slv;

  localparam logic [31:0] BASE = 32'h9000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read, icb_cmd_lock, icb_cmd_excl;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic [1:0]  icb_cmd_size;
  logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err, icb_rsp_excl_ok;
  logic [31:0] icb_rsp_rdata;
  logic        excl_clr;
  logic        ram_cs, ram_we;
  logic [13:0] ram_addr;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din, ram_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  e203_icb_sram_slv dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_cmd_lock(icb_cmd_lock), .icb_cmd_excl(icb_cmd_excl), .icb_cmd_size(icb_cmd_size),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_err(icb_rsp_err), .icb_rsp_excl_ok(icb_rsp_excl_ok), .icb_rsp_rdata(icb_rsp_rdata),
    .excl_clr(excl_clr),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // SRAM macro: byte-masked write, registered read.
  logic [31:0] sram [0:16383];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= sram[ram_addr];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        excl;
    logic        e_err;
    logic        e_eok;
    logic [31:0] e_rdata;
    logic        e_cs;
  } vec_t;

  function automatic vec_t mk(logic [31:0] a, logic rd, logic [1:0] sz, logic [31:0] wd,
                              logic [3:0] wm, logic ex, logic ee, logic eo,
                              logic [31:0] er, logic ec);
    vec_t v;
    v.addr = a; v.rd = rd; v.size = sz; v.wdata = wd; v.wmask = wm; v.excl = ex;
    v.e_err = ee; v.e_eok = eo; v.e_rdata = er; v.e_cs = ec;
    return v;
  endfunction

  vec_t tbl [16];

  task automatic drive(input logic [31:0] a, input logic rd, input logic [1:0] sz,
                       input logic [31:0] wd, input logic [3:0] wm, input logic ex);
    icb_cmd_valid = 1'b1; icb_cmd_addr = a; icb_cmd_read = rd; icb_cmd_size = sz;
    icb_cmd_wdata = wd; icb_cmd_wmask = wm; icb_cmd_excl = ex;
  endtask

  task automatic idle_cmd();
    icb_cmd_valid = 1'b0; icb_cmd_excl = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  // One command with rsp_ready=1, checking its SRAM select and its response next cycle.
  task automatic single(input string nm, input logic [31:0] a, input logic rd,
                        input logic [31:0] wd, input logic ex, input logic clr,
                        input logic e_cs, input logic e_eok, input logic [31:0] e_rd);
    drive(a, rd, 2'd2, wd, 4'hF, ex);
    excl_clr = clr;
    icb_rsp_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_cs"}, 64'(ram_cs), 64'(e_cs));
    next_cyc();
    idle_cmd();
    excl_clr = 1'b0;
    @(negedge clk);
    chk({nm, "_vld"}, 64'(icb_rsp_valid), 64'd1);
    chk({nm, "_eok"}, 64'(icb_rsp_excl_ok), 64'(e_eok));
    chk({nm, "_rdata"}, 64'(icb_rsp_rdata), 64'(e_rd));
    next_cyc();
  endtask

  // Reference model for the random phase.
  typedef struct packed {
    logic        err;
    logic        eok;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mmem [0:3];
  logic        m_vld;
  int          m_word;

  initial begin
    for (int i = 0; i < 16384; i++) sram[i] = 32'h0;
    ram_dout = 32'h0;
    rst_n = 1'b0;
    icb_cmd_valid = 0; icb_cmd_addr = 0; icb_cmd_read = 0; icb_cmd_wdata = 0;
    icb_cmd_wmask = 0; icb_cmd_lock = 0; icb_cmd_excl = 0; icb_cmd_size = 0;
    icb_rsp_ready = 1'b1; excl_clr = 1'b0;

    // Reset state
    #12;
    chk("rst_cmd_ready", 64'(icb_cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(icb_rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(icb_rsp_err), 64'd0);
    chk("rst_rsp_eok", 64'(icb_rsp_excl_ok), 64'd0);
    chk("rst_rsp_rdata", 64'(icb_rsp_rdata), 64'd0);
    chk("rst_ram_cs", 64'(ram_cs), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    next_cyc();

    // Vector table, issued back-to-back with rsp_ready=1
    tbl[0]  = mk(BASE + 32'h10, 0, 2, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0, 1);
    tbl[1]  = mk(BASE + 32'h10, 1, 2, 32'h0, 4'h0, 0, 0, 0, 32'hDEADBEEF, 1);
    tbl[2]  = mk(32'h8000_0000, 1, 2, 32'h0, 4'h0, 0, 1, 0, 32'h0, 0);
    tbl[3]  = mk(BASE + 32'h2,  1, 2, 32'h0, 4'h0, 0, 1, 0, 32'h0, 0);
    tbl[4]  = mk(BASE + 32'h1,  1, 1, 32'h0, 4'h0, 0, 1, 0, 32'h0, 0);
    tbl[5]  = mk(BASE + 32'h13, 1, 0, 32'h0, 4'h0, 0, 0, 0, 32'hDEADBEEF, 1);
    tbl[6]  = mk(BASE + 32'h10, 1, 3, 32'h0, 4'h0, 0, 1, 0, 32'h0, 0);
    tbl[7]  = mk(BASE + 32'h20, 1, 2, 32'h0, 4'h0, 1, 0, 0, 32'h0, 1);
    tbl[8]  = mk(BASE + 32'h20, 0, 2, 32'h55, 4'hF, 1, 0, 1, 32'h0, 1);
    tbl[9]  = mk(BASE + 32'h20, 1, 2, 32'h0, 4'h0, 0, 0, 0, 32'h55, 1);
    tbl[10] = mk(BASE + 32'h20, 0, 2, 32'h77, 4'hF, 1, 0, 0, 32'h0, 0);
    tbl[11] = mk(BASE + 32'h20, 1, 2, 32'h0, 4'h0, 0, 0, 0, 32'h55, 1);
    tbl[12] = mk(BASE + 32'h10, 0, 0, 32'hFFFFFFAA, 4'h1, 0, 0, 0, 32'h0, 1);
    tbl[13] = mk(BASE + 32'h10, 1, 2, 32'h0, 4'h0, 0, 0, 0, 32'hDEADBEAA, 1);
    tbl[14] = mk(32'h9001_0010, 0, 2, 32'h1234, 4'hF, 0, 1, 0, 32'h0, 0);
    tbl[15] = mk(BASE + 32'h10, 1, 2, 32'h0, 4'h0, 0, 0, 0, 32'hDEADBEAA, 1);

    icb_rsp_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) drive(tbl[i].addr, tbl[i].rd, tbl[i].size, tbl[i].wdata, tbl[i].wmask, tbl[i].excl);
      else idle_cmd();
      @(negedge clk);
      if (i < 16) begin
        chk($sformatf("tbl%0d_ready", i), 64'(icb_cmd_ready), 64'd1);
        chk($sformatf("tbl%0d_cs", i), 64'(ram_cs), 64'(tbl[i].e_cs));
      end
      if (i == 0) chk("tbl0_no_early_rsp", 64'(icb_rsp_valid), 64'd0);
      else begin
        chk($sformatf("tbl%0d_vld", i-1), 64'(icb_rsp_valid), 64'd1);
        chk($sformatf("tbl%0d_err", i-1), 64'(icb_rsp_err), 64'(tbl[i-1].e_err));
        chk($sformatf("tbl%0d_eok", i-1), 64'(icb_rsp_excl_ok), 64'(tbl[i-1].e_eok));
        chk($sformatf("tbl%0d_rdata", i-1), 64'(icb_rsp_rdata), 64'(tbl[i-1].e_rdata));
      end
      next_cyc();
    end
    @(negedge clk);
    chk("tbl_drained", 64'(icb_rsp_valid), 64'd0);
    next_cyc();

    // Back-pressure: three reads with rsp_ready low
    icb_rsp_ready = 1'b0;
    drive(BASE + 32'h10, 1, 2, 0, 0, 0);
    @(negedge clk);
    chk("bp_c0_ready", 64'(icb_cmd_ready), 64'd1);
    chk("bp_c0_vld", 64'(icb_rsp_valid), 64'd0);
    next_cyc();
    drive(BASE + 32'h20, 1, 2, 0, 0, 0);
    @(negedge clk);
    chk("bp_c1_ready", 64'(icb_cmd_ready), 64'd1);
    chk("bp_c1_rdata", 64'(icb_rsp_rdata), 64'hDEADBEAA);
    next_cyc();
    drive(BASE + 32'h14, 1, 2, 0, 0, 0);
    @(negedge clk);
    chk("bp_c2_ready", 64'(icb_cmd_ready), 64'd0);
    chk("bp_c2_cs", 64'(ram_cs), 64'd0);
    chk("bp_c2_rdata", 64'(icb_rsp_rdata), 64'hDEADBEAA);
    next_cyc();
    icb_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_c3_ready", 64'(icb_cmd_ready), 64'd0);
    chk("bp_c3_vld", 64'(icb_rsp_valid), 64'd1);
    chk("bp_c3_rdata", 64'(icb_rsp_rdata), 64'hDEADBEAA);
    next_cyc();
    @(negedge clk);
    chk("bp_c4_ready", 64'(icb_cmd_ready), 64'd1);
    chk("bp_c4_cs", 64'(ram_cs), 64'd1);
    chk("bp_c4_rdata", 64'(icb_rsp_rdata), 64'h55);
    next_cyc();
    idle_cmd();
    @(negedge clk);
    chk("bp_c5_vld", 64'(icb_rsp_valid), 64'd1);
    chk("bp_c5_rdata", 64'(icb_rsp_rdata), 64'h0);
    next_cyc();
    @(negedge clk);
    chk("bp_c6_vld", 64'(icb_rsp_valid), 64'd0);
    next_cyc();

    // Exclusive monitor corner cases
    single("ex_rd1", BASE + 32'h40, 1, 0, 1, 0, 1, 0, 32'h0);
    excl_clr = 1'b1; next_cyc(); excl_clr = 1'b0;
    single("ex_wr_after_clr", BASE + 32'h40, 0, 32'h99, 1, 0, 0, 0, 32'h0);
    single("ex_rd_with_clr", BASE + 32'h40, 1, 0, 1, 1, 1, 0, 32'h0);
    single("ex_wr_clr_prio", BASE + 32'h40, 0, 32'h99, 1, 0, 0, 0, 32'h0);
    single("ex_rd2", BASE + 32'h40, 1, 0, 1, 0, 1, 0, 32'h0);
    single("plain_wr", BASE + 32'h40, 0, 32'h11, 0, 0, 1, 0, 32'h0);
    single("ex_wr_after_plain", BASE + 32'h40, 0, 32'h22, 1, 0, 0, 0, 32'h0);
    single("rd_back", BASE + 32'h40, 1, 0, 0, 0, 1, 0, 32'h11);

    // Asynchronous reset with two responses buffered
    icb_rsp_ready = 1'b0;
    drive(BASE + 32'h10, 1, 2, 0, 0, 0); next_cyc();
    drive(BASE + 32'h20, 1, 2, 0, 0, 0); next_cyc();
    idle_cmd();
    @(negedge clk);
    chk("rr_full_vld", 64'(icb_rsp_valid), 64'd1);
    chk("rr_full_ready", 64'(icb_cmd_ready), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rr_async_vld", 64'(icb_rsp_valid), 64'd0);
    chk("rr_async_ready", 64'(icb_cmd_ready), 64'd1);
    chk("rr_async_rdata", 64'(icb_rsp_rdata), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    icb_rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      @(negedge clk);
      chk($sformatf("rr_post%0d_vld", k), 64'(icb_rsp_valid), 64'd0);
      chk($sformatf("rr_post%0d_ready", k), 64'(icb_cmd_ready), 64'd1);
    end
    next_cyc();

    // Randomized traffic against the reference model
    for (int i = 0; i < 4; i++) mmem[i] = 32'h0;
    m_vld = 1'b0; m_word = 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      int          w, sel, szr;
      logic [31:0] a;
      logic        exp_rdy, exp_vld, acc, e_err, e_eok, e_cs;
      logic [31:0] e_rd;
      w   = $urandom_range(0, 3);
      sel = $urandom_range(0, 15);
      if (sel == 0) a = 32'h8000_1000 + 32'(w * 4);
      else if (sel == 1) a = BASE + 32'h1000 + 32'(w * 4) + 32'($urandom_range(1, 3));
      else a = BASE + 32'h1000 + 32'(w * 4);
      szr = $urandom_range(0, 9);
      drive(a, 1'($urandom_range(0, 1)),
            (szr == 0) ? 2'd0 : (szr == 1) ? 2'd1 : (szr == 2) ? 2'd3 : 2'd2,
            $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      icb_cmd_valid = ($urandom_range(0, 9) < 7);
      icb_rsp_ready = ($urandom_range(0, 9) < 7);
      excl_clr      = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      exp_rdy = (q.size() < 2);
      exp_vld = (q.size() > 0) && (q[0].cyc < cyc);
      chk("rnd_ready", 64'(icb_cmd_ready), 64'(exp_rdy));
      chk("rnd_vld", 64'(icb_rsp_valid), 64'(exp_vld));
      if (exp_vld) begin
        chk("rnd_err", 64'(icb_rsp_err), 64'(q[0].err));
        chk("rnd_eok", 64'(icb_rsp_excl_ok), 64'(q[0].eok));
        chk("rnd_rdata", 64'(icb_rsp_rdata), 64'(q[0].rdata));
      end
      acc  = icb_cmd_valid && exp_rdy;
      e_cs = 1'b0; e_eok = 1'b0; e_rd = 32'h0; e_err = 1'b0;
      if (acc) begin
        e_err = (a[31:16] != BASE[31:16]) || (icb_cmd_size == 2'd3) ||
                (icb_cmd_size == 2'd1 && a[0]) || (icb_cmd_size == 2'd2 && a[1:0] != 2'b00);
        if (!e_err) begin
          if (icb_cmd_read) begin
            e_rd = mmem[w];
            e_cs = 1'b1;
            if (icb_cmd_excl) begin m_vld = 1'b1; m_word = w; end
          end else begin
            if (icb_cmd_excl) e_eok = m_vld && (m_word == w);
            e_cs = !icb_cmd_excl || e_eok;
            if (e_cs)
              for (int b = 0; b < 4; b++)
                if (icb_cmd_wmask[b]) mmem[w][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
            if (icb_cmd_excl || (m_vld && m_word == w)) m_vld = 1'b0;
          end
        end
        q.push_back('{err: e_err, eok: e_eok, rdata: e_rd, cyc: cyc});
      end
      chk("rnd_cs", 64'(ram_cs), 64'(e_cs));
      if (e_cs)
        chk("rnd_ram_bus", {13'd0, ram_we, ram_wem, ram_addr, ram_din},
            {13'd0, ~icb_cmd_read, icb_cmd_read ? 4'h0 : icb_cmd_wmask, a[15:2], icb_cmd_wdata});
      if (excl_clr) m_vld = 1'b0;
      if (exp_vld && icb_rsp_ready) void'(q.pop_front());
      next_cyc();
    end
    idle_cmd();
    excl_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
